// File: rtl/reset_seq.sv
// reset_seq: staged release of NCH active-low resets after a master or external reset, plus per-channel software resets
module reset_seq #(
  parameter int NCH  = 4,
  parameter int HOLD = 16,
  parameter int GAP  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ext_req,
  input  logic [NCH-1:0] sw_rst,
  output logic [NCH-1:0] rst_n,
  output logic           done,
  output logic           busy,
  output logic [7:0]     restart_cnt
);
  localparam int CNTW = $clog2((HOLD > GAP ? HOLD : GAP) + 1);
  localparam int IW   = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
  state_t                   r_state, w_state_nxt;
  logic [CNTW-1:0]          r_cnt, w_cnt_nxt;
  logic [IW-1:0]            r_idx, w_idx_nxt;
  logic [NCH-1:0]           r_rst_n, w_rst_n_nxt;
  logic [NCH-1:0][CNTW-1:0] r_sw_cnt, w_sw_cnt_nxt;
  logic                     r_done, w_done_nxt, r_busy, r_ext_q;
  logic [7:0]               r_restart_cnt;
  logic                     w_restart, w_hold_end, w_gap_end, w_last;
  assign w_restart  = reset | ext_req;
  assign w_hold_end = r_cnt == CNTW'(HOLD - 1);
  assign w_gap_end  = r_cnt == CNTW'(GAP - 1);
  assign w_last     = r_idx == IW'(NCH - 1);
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_state  <= ASSERT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rst_n  <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b1;
      r_sw_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= ~w_done_nxt;
      r_sw_cnt <= w_sw_cnt_nxt;
    end
  end
  // only a fresh ext_req edge counts a restart; master reset wins
  always_ff @(posedge clk) begin
    r_ext_q <= ext_req;
    if (reset) r_restart_cnt <= '0;
    else if (ext_req && !r_ext_q && r_restart_cnt != 8'hFF) r_restart_cnt <= r_restart_cnt + 8'd1;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ASSERT && w_hold_end) w_state_nxt = NCH == 1 ? RUN : RELEASE;
    else if (r_state == RELEASE && w_gap_end && w_last) w_state_nxt = RUN;
  end
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_rst_n_nxt  = r_rst_n;
    w_done_nxt   = r_done;
    w_sw_cnt_nxt = r_sw_cnt;
    case (r_state)
      ASSERT: begin
        w_cnt_nxt = w_hold_end ? '0 : r_cnt + CNTW'(1);
        if (w_hold_end) begin
          w_idx_nxt      = IW'(1);
          w_rst_n_nxt[0] = 1'b1;
          w_done_nxt     = NCH == 1;
        end
      end
      RELEASE: begin
        w_cnt_nxt = w_gap_end ? '0 : r_cnt + CNTW'(1);
        if (w_gap_end) begin
          w_idx_nxt          = w_last ? r_idx : r_idx + IW'(1);
          w_rst_n_nxt[r_idx] = 1'b1;
          w_done_nxt         = w_last;
        end
      end
      default: begin
        // a low channel in RUN is always a software reset counting down
        for (int i = 0; i < NCH; i++) begin
          if (sw_rst[i]) begin
            w_rst_n_nxt[i]  = 1'b0;
            w_sw_cnt_nxt[i] = CNTW'(HOLD - 1);
          end else if (!r_rst_n[i]) begin
            w_rst_n_nxt[i]  = r_sw_cnt[i] == '0;
            w_sw_cnt_nxt[i] = r_sw_cnt[i] == '0 ? '0 : r_sw_cnt[i] - CNTW'(1);
          end
        end
      end
    endcase
  end
  assign rst_n       = r_rst_n;
  assign done        = r_done;
  assign busy        = r_busy;
  assign restart_cnt = r_restart_cnt;
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: edge-stamped expectations queued by the stimulus, checked by an independent monitor
module tb_reset_seq;
  logic       clk = 1'b0, reset = 1'b1, ext_req = 1'b0, ext_off = 1'b0;
  logic [3:0] sw_rst = '0;
  logic [0:0] sw1 = '0;
  logic [7:0] sw8 = '0;
  logic [3:0] rn0;
  logic [0:0] rn1;
  logic [7:0] rn2, rc0, rc1, rc2;
  logic       dn0, dn1, dn2, bz0, bz1, bz2;
  int cyc = 0, checks = 0, errors = 0, e0, p, s;
  logic [7:0] a_r, a_c;
  logic       a_d, a_b;
  typedef struct {int cyc; int dut; logic [7:0] rst_n; logic done; logic [7:0] rc;} exp_t;
  exp_t sb[$];

  reset_seq dut0 (.clk(clk), .reset(reset), .ext_req(ext_req), .sw_rst(sw_rst),
                  .rst_n(rn0), .done(dn0), .busy(bz0), .restart_cnt(rc0));
  reset_seq #(.NCH(1), .HOLD(1), .GAP(1)) dut1 (.clk(clk), .reset(reset), .ext_req(ext_off),
                  .sw_rst(sw1), .rst_n(rn1), .done(dn1), .busy(bz1), .restart_cnt(rc1));
  reset_seq #(.NCH(8), .HOLD(3), .GAP(7)) dut2 (.clk(clk), .reset(reset), .ext_req(ext_off),
                  .sw_rst(sw8), .rst_n(rn2), .done(dn2), .busy(bz2), .restart_cnt(rc2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int k, input int d, input logic [7:0] r, input logic dn, input logic [7:0] rc);
    sb.push_back('{k, d, r, dn, rc});
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic rst_pulse(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].dut)
          0: begin a_r = {4'b0, rn0}; a_d = dn0; a_b = bz0; a_c = rc0; end
          1: begin a_r = {7'b0, rn1}; a_d = dn1; a_b = bz1; a_c = rc1; end
          default: begin a_r = rn2; a_d = dn2; a_b = bz2; a_c = rc2; end
        endcase
        checks++;
        if (a_r !== sb[i].rst_n || a_d !== sb[i].done || a_b !== ~sb[i].done || a_c !== sb[i].rc) begin
          errors++;
          $display("FAIL dut%0d edge %0d: rst_n=%h done=%b busy=%b restart_cnt=%0d, required rst_n=%h done=%b busy=%b restart_cnt=%0d",
                   sb[i].dut, cyc, a_r, a_d, a_b, a_c, sb[i].rst_n, sb[i].done, ~sb[i].done, sb[i].rc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    @(negedge clk);
    // power-on sequence on all three parameterisations
    e0 = cyc + 3;
    expect_at(e0, 0, 8'h0, 1'b0, 8'd0);
    expect_at(e0 + 15, 0, 8'h0, 1'b0, 8'd0);
    expect_at(e0 + 16, 0, 8'h1, 1'b0, 8'd0);
    expect_at(e0 + 19, 0, 8'h1, 1'b0, 8'd0);
    expect_at(e0 + 20, 0, 8'h3, 1'b0, 8'd0);
    expect_at(e0 + 24, 0, 8'h7, 1'b0, 8'd0);
    expect_at(e0 + 27, 0, 8'h7, 1'b0, 8'd0);
    expect_at(e0 + 28, 0, 8'hF, 1'b1, 8'd0);
    expect_at(e0, 1, 8'h0, 1'b0, 8'd0);
    expect_at(e0 + 1, 1, 8'h1, 1'b1, 8'd0);
    expect_at(e0 + 2, 2, 8'h00, 1'b0, 8'd0);
    expect_at(e0 + 3, 2, 8'h01, 1'b0, 8'd0);
    expect_at(e0 + 44, 2, 8'h3F, 1'b0, 8'd0);
    expect_at(e0 + 45, 2, 8'h7F, 1'b0, 8'd0);
    expect_at(e0 + 51, 2, 8'h7F, 1'b0, 8'd0);
    expect_at(e0 + 52, 2, 8'hFF, 1'b1, 8'd0);
    rst_pulse(3);
    wait_until(e0 + 53);
    // ext_req mid-sequence
    e0 = cyc + 1;
    p = e0 + 22;
    expect_at(e0 + 21, 0, 8'h3, 1'b0, 8'd0);
    expect_at(p, 0, 8'h0, 1'b0, 8'd1);
    expect_at(p + 15, 0, 8'h0, 1'b0, 8'd1);
    expect_at(p + 16, 0, 8'h1, 1'b0, 8'd1);
    expect_at(p + 27, 0, 8'h7, 1'b0, 8'd1);
    expect_at(p + 28, 0, 8'hF, 1'b1, 8'd1);
    rst_pulse(1);
    wait_until(e0 + 21);
    ext_req = 1'b1;
    @(negedge clk);
    ext_req = 1'b0;
    wait_until(p + 29);
    // software reset of channel 2
    s = cyc + 1;
    expect_at(s, 0, 8'hB, 1'b1, 8'd1);
    expect_at(s + 15, 0, 8'hB, 1'b1, 8'd1);
    expect_at(s + 16, 0, 8'hF, 1'b1, 8'd1);
    sw_rst = 4'b0100;
    @(negedge clk);
    sw_rst = '0;
    wait_until(s + 17);
    // re-pulse restarts the hold count
    s = cyc + 1;
    expect_at(s, 0, 8'hB, 1'b1, 8'd1);
    expect_at(s + 16, 0, 8'hB, 1'b1, 8'd1);
    expect_at(s + 25, 0, 8'hB, 1'b1, 8'd1);
    expect_at(s + 26, 0, 8'hF, 1'b1, 8'd1);
    sw_rst = 4'b0100;
    @(negedge clk);
    sw_rst = '0;
    wait_until(s + 9);
    sw_rst = 4'b0100;
    @(negedge clk);
    sw_rst = '0;
    wait_until(s + 27);
    // two channels at once
    s = cyc + 1;
    expect_at(s, 0, 8'hC, 1'b1, 8'd1);
    expect_at(s + 15, 0, 8'hC, 1'b1, 8'd1);
    expect_at(s + 16, 0, 8'hF, 1'b1, 8'd1);
    sw_rst = 4'b0011;
    @(negedge clk);
    sw_rst = '0;
    wait_until(s + 17);
    // sw_rst during RELEASE is ignored
    e0 = cyc + 1;
    expect_at(e0, 0, 8'h0, 1'b0, 8'd0);
    expect_at(e0 + 16, 0, 8'h1, 1'b0, 8'd0);
    expect_at(e0 + 17, 0, 8'h1, 1'b0, 8'd0);
    expect_at(e0 + 20, 0, 8'h3, 1'b0, 8'd0);
    expect_at(e0 + 24, 0, 8'h7, 1'b0, 8'd0);
    expect_at(e0 + 27, 0, 8'h7, 1'b0, 8'd0);
    expect_at(e0 + 28, 0, 8'hF, 1'b1, 8'd0);
    rst_pulse(1);
    wait_until(e0 + 16);
    sw_rst = 4'hF;
    @(negedge clk);
    sw_rst = '0;
    wait_until(e0 + 29);
    // ext_req beats sw_rst on the same edge
    p = cyc + 1;
    expect_at(p, 0, 8'h0, 1'b0, 8'd1);
    expect_at(p + 1, 0, 8'h0, 1'b0, 8'd1);
    expect_at(p + 16, 0, 8'h1, 1'b0, 8'd1);
    expect_at(p + 28, 0, 8'hF, 1'b1, 8'd1);
    ext_req = 1'b1;
    sw_rst = 4'b0010;
    @(negedge clk);
    ext_req = 1'b0;
    sw_rst = '0;
    wait_until(p + 29);
    // reset beats a coincident ext_req rise
    p = cyc + 1;
    expect_at(p, 0, 8'h0, 1'b0, 8'd0);
    expect_at(p + 1, 0, 8'h0, 1'b0, 8'd0);
    expect_at(p + 2, 0, 8'h0, 1'b0, 8'd0);
    reset = 1'b1;
    ext_req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ext_req = 1'b0;
    wait_until(p + 3);
    // restart_cnt saturation
    for (int i = 0; i < 300; i++) begin
      ext_req = 1'b1;
      @(negedge clk);
      ext_req = 1'b0;
      if (i == 99 || i == 253 || i == 254 || i == 299)
        expect_at(cyc + 1, 0, 8'h0, 1'b0, 8'(i + 1 > 255 ? 255 : i + 1));
      @(negedge clk);
    end
    e0 = cyc + 1;
    expect_at(e0, 0, 8'h0, 1'b0, 8'd0);
    expect_at(e0 + 16, 0, 8'h1, 1'b0, 8'd0);
    rst_pulse(1);
    wait_until(e0 + 17);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
